// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS receive framer.
// The six framing states, the default sync pairs and the frame geometry.
package lvds_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        I_DATA,
        Q_SYNC,
        Q_DATA,
        I_SYNC
    } state_t;

    localparam logic [1:0]  SYNC_I          = 2'b10;
    localparam logic [1:0]  SYNC_Q          = 2'b01;
    localparam int unsigned FIELD_W         = 14;
    localparam int unsigned PAIRS_PER_FIELD = 7;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones and never wraps.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_sys_clk,
    input  logic         i_reset_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/lvds_rx_framer.sv
// Sync hunt and word assembly for the de-serialised I/Q LVDS stream.
// Each 16-pair frame becomes one 32-bit push into the RX FIFO.
module lvds_rx_framer
    import lvds_rx_pkg::*;
#(
    parameter logic [1:0]  SYNC_I = lvds_rx_pkg::SYNC_I,
    parameter logic [1:0]  SYNC_Q = lvds_rx_pkg::SYNC_Q,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             i_sys_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic [1:0]       i_ddr_data,
    input  logic             i_fifo_full,
    output logic             o_fifo_push,
    output logic [31:0]      o_fifo_pushed_data,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_sync_err_cnt,
    output logic [CNT_W-1:0] o_overflow_cnt
);

    localparam logic [2:0] LAST_PAIR = 3'(PAIRS_PER_FIELD - 1);

    state_t      state, state_nxt;
    logic [2:0]  pair_cnt, pair_cnt_nxt;
    logic [29:0] shreg;
    logic [31:0] word_nxt;
    logic        push_nxt, locked_nxt, sync_err, overflow;

    // The shift register keeps the last 15 pairs, so word_nxt is the full frame on the 16th.
    assign word_nxt = {shreg, i_ddr_data};

    always_comb begin
        state_nxt    = state;
        pair_cnt_nxt = pair_cnt;
        push_nxt     = 1'b0;
        locked_nxt   = o_locked;
        sync_err     = 1'b0;
        overflow     = 1'b0;
        if (!i_enable) begin
            state_nxt    = IDLE;
            pair_cnt_nxt = '0;
            locked_nxt   = 1'b0;
        end else begin
            unique case (state)
                IDLE: state_nxt = HUNT;
                HUNT: begin
                    if (i_ddr_data == SYNC_I) begin
                        state_nxt    = I_DATA;
                        pair_cnt_nxt = '0;
                    end
                end
                I_DATA: begin
                    if (pair_cnt == LAST_PAIR) begin
                        state_nxt    = Q_SYNC;
                        pair_cnt_nxt = '0;
                    end else begin
                        pair_cnt_nxt = pair_cnt + 3'd1;
                    end
                end
                Q_SYNC: begin
                    if (i_ddr_data == SYNC_Q) begin
                        state_nxt = Q_DATA;
                    end else begin
                        state_nxt  = HUNT;
                        sync_err   = 1'b1;
                        locked_nxt = 1'b0;
                    end
                end
                Q_DATA: begin
                    if (pair_cnt == LAST_PAIR) begin
                        state_nxt    = I_SYNC;
                        pair_cnt_nxt = '0;
                        if (i_fifo_full) begin
                            overflow = 1'b1;
                        end else begin
                            push_nxt   = 1'b1;
                            locked_nxt = 1'b1;
                        end
                    end else begin
                        pair_cnt_nxt = pair_cnt + 3'd1;
                    end
                end
                I_SYNC: begin
                    if (i_ddr_data == SYNC_I) begin
                        state_nxt = I_DATA;
                    end else begin
                        state_nxt  = HUNT;
                        sync_err   = 1'b1;
                        locked_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state              <= IDLE;
            pair_cnt           <= '0;
            shreg              <= '0;
            o_fifo_push        <= 1'b0;
            o_fifo_pushed_data <= '0;
            o_locked           <= 1'b0;
        end else begin
            state       <= state_nxt;
            pair_cnt    <= pair_cnt_nxt;
            o_fifo_push <= push_nxt;
            o_locked    <= locked_nxt;
            shreg       <= (state_nxt == IDLE) ? '0 : word_nxt[29:0];
            if (push_nxt) begin
                o_fifo_pushed_data <= word_nxt;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_sync_err_cnt (
        .i_sys_clk (i_sys_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (sync_err),
        .o_count   (o_sync_err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_overflow_cnt (
        .i_sys_clk (i_sys_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (overflow),
        .o_count   (o_overflow_cnt)
    );

endmodule

// File: doc/lvds_rx_framer.md
# lvds_rx_framer

Receive-side framer upstream of the SMI controller's 0.9 GHz read FIFO. It takes the modem's I/Q LVDS stream, already de-serialised to two bits per clock, and hunts for the sync pattern. Each 16-pair frame is assembled into one 32-bit I/Q word and pushed into the RX FIFO that the SMI controller drains. Sync loss and FIFO overflow are counted for host visibility through the IOC status path.

## Interface
Parameters:
- `SYNC_I`, 2'b10, sync pair that precedes the I field.
- `SYNC_Q`, 2'b01, sync pair that precedes the Q field.
- `CNT_W`, 8, width of the saturating error counters.

Ports:
- `i_sys_clk`  in  1  single clock; all logic runs on its rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  framing enable; low forces IDLE.
- `i_ddr_data`  in  2  one sample pair per clock; bit 1 is first in time.
- `i_fifo_full`  in  1  RX FIFO full.
- `o_fifo_push`  out  1  one-cycle write strobe.
- `o_fifo_pushed_data`  out  32  assembled word, `{SYNC_I, I[13:0], SYNC_Q, Q[13:0]}`.
- `o_locked`  out  1  high while frames arrive back-to-back without a sync error.
- `o_sync_err_cnt`  out  CNT_W  saturating count of sync errors.
- `o_overflow_cnt`  out  CNT_W  saturating count of words dropped on FIFO full.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE; the shift register and pair counter are 0.
- States:
  - IDLE: leave to HUNT when `i_enable`=1.
  - HUNT: when the pair equals `SYNC_I`, go to I_DATA and clear the pair counter.
  - I_DATA: shift in 7 pairs (counter 0..6); after the 7th, go to Q_SYNC.
  - Q_SYNC:
    - Pair equals `SYNC_Q`: go to Q_DATA.
    - Any other pair: increment the sync error count, drop `o_locked`, go to HUNT.
  - Q_DATA: shift in 7 pairs; the 7th completes the word; then go to I_SYNC.
  - I_SYNC:
    - Pair equals `SYNC_I`: go to I_DATA.
    - Any other pair: increment the sync error count, drop `o_locked`, go to HUNT.
- HUNT never counts errors. The first-word mismatch at Q_SYNC does count.
- `o_locked` rises together with the first push after HUNT. It falls on any sync error or when leaving the enabled states.
- Word assembly: 32-bit left shift, 2 bits per clock. The sync pairs are stored in the word, so the SMI side sees the raw modem word.
- Push rule, evaluated in the cycle the word completes:
  - `i_fifo_full`=0: `o_fifo_push`=1 next cycle, with the data.
  - `i_fifo_full`=1: no push; `o_overflow_cnt` increments. Framing continues and stays locked.
- Counters saturate at 2^CNT_W−1 and never wrap. They clear only on reset.
- `i_enable` falling mid-frame:
  - Next state is IDLE and the partial word is discarded.
  - No push and no error count.
  - A push already scheduled for the next cycle still completes.
- A sync error and an overflow cannot occur in the same cycle; no priority logic is needed.

## Timing
- Word period: 16 clocks per word at steady state.
- Latency: `o_fifo_push` asserts 1 clock after the clock that samples the 16th pair.
- `o_fifo_pushed_data` is registered, valid only while `o_fifo_push`=1, and held otherwise.
- `o_fifo_push` is never high on two consecutive clocks.
- Counters update 1 clock after the triggering pair. `o_locked` changes on the same edge as the state change.
- Asynchronous reset mid-word:
  - Everything clears immediately and the pending push is cancelled.
  - After release, the first push comes no earlier than 17 clocks later (HUNT plus a full frame).

## Structure
- Package `lvds_rx_pkg`:
  - State enum IDLE/HUNT/I_DATA/Q_SYNC/Q_DATA/I_SYNC.
  - Constants `SYNC_I`/`SYNC_Q`, the I/Q field width of 14, and the pairs-per-field value of 7.
- Sub-module `sat_counter` (parameter W; ports `i_sys_clk`, `i_reset_n`, `i_inc`, `o_count`), instantiated twice.
- Top level holds the FSM, the 3-bit pair counter, the shift register and the push register.

## Test plan
- Reset, then `i_enable`=1, then a clean frame with I=14'h1234, Q=14'h0ABC → one push of 32'h9234_4ABC one clock after the 16th pair; `o_locked`=1; both counters 0.
- 10 back-to-back clean frames → exactly 10 pushes, spaced 16 clocks apart; `o_locked` stays 1.
- Third frame's Q sync pair set to 2'b11 → `o_sync_err_cnt`=1, no push for that frame, `o_locked`=0, relock and push on the next frame.
- `i_fifo_full`=1 during two frame completions out of 5 frames → 3 pushes, `o_overflow_cnt`=2, `o_locked` stays 1.
- 300 consecutive corrupted Q sync pairs → `o_sync_err_cnt` saturates at 255 and does not wrap.
- Reset asserted at pair 10 of a frame, then `i_enable` dropped at pair 5 of another frame → no push from either partial frame; counters unchanged, except that reset clears them to 0.
